note_bram_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single read port of the 512x16 note BRAM between two clients: the note loader/scorer (port 0) and the note renderer (port 1). It accepts at most one read per cycle, forwards it to the BRAM, and tracks each read through the BRAM's fixed read latency. It then returns the read data to the requester that issued it. It sits directly in front of the note BRAM and is the only block that drives its address and enable.

---
 rtl/note_bram_arbiter_if.sv | 38 +++
 rtl/note_bram_arbiter.sv | 103 ++++++++++
 tb/tb_note_bram_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/note_bram_arbiter_if.sv
// Request/response bundle between the two note BRAM clients, the arbiter
// and the BRAM read port.
interface note_bram_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_data;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_data;

    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_addr, req1_valid, req1_addr, bram_dout,
        output req0_ready, rsp0_valid, rsp0_data,
        output req1_ready, rsp1_valid, rsp1_data,
        output bram_en, bram_addr
    );

    // Client and BRAM side.
    modport master (
        output req0_valid, req0_addr, req1_valid, req1_addr, bram_dout,
        input  req0_ready, rsp0_valid, rsp0_data,
        input  req1_ready, rsp1_valid, rsp1_data,
        input  bram_en, bram_addr
    );
endinterface

// File: rtl/note_bram_arbiter.sv
// Round-robin arbiter sharing the note BRAM read port between the loader/scorer
// (port 0) and the renderer (port 1); read data is routed back by a tag pipeline.
module note_bram_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    note_bram_arbiter_if.slave    bus
);
    logic               r_last;
    logic [LATENCY-1:0] r_tag_valid;
    logic [LATENCY-1:0] r_tag_port;
    logic               r_rsp0_valid;
    logic               r_rsp1_valid;
    logic [DATA_W-1:0]  r_rsp0_data;
    logic [DATA_W-1:0]  r_rsp1_data;

    logic               w_grant0;
    logic               w_grant1;
    logic               w_fire;
    logic               w_out_valid;
    logic               w_out_port;

    // r_last names the port granted most recently; a tie goes to the other one.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (reset_n) begin
            if (bus.req0_valid && bus.req1_valid) begin
                w_grant0 = r_last;
                w_grant1 = !r_last;
            end else begin
                w_grant0 = bus.req0_valid;
                w_grant1 = bus.req1_valid;
            end
        end
    end

    assign w_fire         = w_grant0 || w_grant1;
    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.bram_en    = w_fire;
    assign bus.bram_addr  = w_grant0 ? bus.req0_addr :
                            (w_grant1 ? bus.req1_addr : '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last <= 1'b1;
        end else if (w_fire) begin
            r_last <= w_grant1;
        end
    end

    // Tag reaches the last stage in the same cycle its data appears on bram_dout.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tag_valid <= '0;
            r_tag_port  <= '0;
        end else begin
            r_tag_valid[0] <= w_fire;
            r_tag_port[0]  <= w_grant1;
            for (int i = LATENCY - 1; i > 0; i--) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_port[i]  <= r_tag_port[i-1];
            end
        end
    end

    assign w_out_valid = r_tag_valid[LATENCY-1];
    assign w_out_port  = r_tag_port[LATENCY-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_data  <= '0;
            r_rsp1_data  <= '0;
        end else begin
            r_rsp0_valid <= w_out_valid && !w_out_port;
            r_rsp1_valid <= w_out_valid && w_out_port;
            if (w_out_valid && !w_out_port) begin
                r_rsp0_data <= bus.bram_dout;
            end
            if (w_out_valid && w_out_port) begin
                r_rsp1_data <= bus.bram_dout;
            end
        end
    end

    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp0_data  = r_rsp0_data;
    assign bus.rsp1_data  = r_rsp1_data;

    // A waiting requester may withdraw, but must not move its address.
    a_req0_addr_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (bus.req0_valid && !bus.req0_ready) |=> (!bus.req0_valid || $stable(bus.req0_addr)));
    a_req1_addr_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (bus.req1_valid && !bus.req1_ready) |=> (!bus.req1_valid || $stable(bus.req1_addr)));

endmodule

// File: tb/tb_note_bram_arbiter.sv
// Scoreboard bench for note_bram_arbiter: a LATENCY=2 and a LATENCY=1 instance,
// each in front of a behavioural BRAM holding mem[a] = 0x100 + a.
module tb_note_bram_arbiter;
    typedef struct {
        int          port;
        logic [15:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    exp_t        q_l2[$];
    exp_t        q_l1[$];
    logic [15:0] hold [2][2];

    logic [15:0] b2_q0, b2_q1, b1_q0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    note_bram_arbiter_if #(.ADDR_W(9), .DATA_W(16)) if2 ();
    note_bram_arbiter_if #(.ADDR_W(9), .DATA_W(16)) if1 ();

    note_bram_arbiter #(.ADDR_W(9), .DATA_W(16), .LATENCY(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(if2.slave));
    note_bram_arbiter #(.ADDR_W(9), .DATA_W(16), .LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1.slave));

    function automatic logic [15:0] mem_word(input logic [8:0] a);
        return 16'h0100 + {7'd0, a};
    endfunction

    // Behavioural BRAMs; 0xDEAD marks a cycle without a read enable.
    always @(posedge clk) begin
        b2_q0 <= if2.bram_en ? mem_word(if2.bram_addr) : 16'hDEAD;
        b2_q1 <= b2_q0;
        b1_q0 <= if1.bram_en ? mem_word(if1.bram_addr) : 16'hDEAD;
    end
    assign if2.bram_dout = b2_q1;
    assign if1.bram_dout = b1_q0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q_l2.size() : q_l1.size();
    endfunction

    function automatic exp_t qpop(input int d);
        exp_t e;
        if (d == 0) e = q_l2.pop_front();
        else        e = q_l1.pop_front();
        return e;
    endfunction

    function automatic int qdue(input int d);
        exp_t e;
        if (d == 0) e = q_l2[0];
        else        e = q_l1[0];
        return e.due;
    endfunction

    // Reads in flight at a reset edge are dropped and held data returns to 0.
    always @(posedge clk) begin
        if (!reset_n) begin
            q_l2.delete();
            q_l1.delete();
            for (int d = 0; d < 2; d++) begin
                hold[d][0] = 16'h0;
                hold[d][1] = 16'h0;
            end
            mon_en = 1'b1;
        end
    end

    task automatic mon(input int d, input logic rv0, input logic rv1,
                       input logic [15:0] rd0, input logic [15:0] rd1);
        exp_t e;
        int   p;
        logic [15:0] got;
        while (qsize(d) > 0 && qdue(d) < cyc) begin
            e = qpop(d);
            n_checks++;
            n_fail++;
            $display("FAIL missed_rsp dut%0d at cycle %0d: got none expected port %0d data %0h",
                     d, cyc, e.port, e.data);
        end
        if (rv0 || rv1) begin
            chk($sformatf("one_rsp_per_cycle_dut%0d", d), {31'd0, rv0 && rv1}, 32'd0);
            p   = rv1 ? 1 : 0;
            got = rv1 ? rd1 : rd0;
            if (qsize(d) == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp dut%0d at cycle %0d: got port %0d data %0h expected none",
                         d, cyc, p, got);
            end else begin
                e = qpop(d);
                chk($sformatf("rsp_port_dut%0d", d), p, e.port);
                chk($sformatf("rsp_data_dut%0d", d), {16'd0, got}, {16'd0, e.data});
                chk($sformatf("rsp_cycle_dut%0d", d), cyc, e.due);
                hold[d][e.port] = e.data;
            end
        end
        chk($sformatf("rsp0_data_hold_dut%0d", d), {16'd0, rd0}, {16'd0, hold[d][0]});
        chk($sformatf("rsp1_data_hold_dut%0d", d), {16'd0, rd1}, {16'd0, hold[d][1]});
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, if2.rsp0_valid, if2.rsp1_valid, if2.rsp0_data, if2.rsp1_data);
            mon(1, if1.rsp0_valid, if1.rsp1_valid, if1.rsp0_data, if1.rsp1_data);
        end
    end

    // One cycle of stimulus on instance sel (0: LATENCY=2, 1: LATENCY=1) with expected grants.
    task automatic step(input int sel, input logic rn,
                        input logic v0, input logic [8:0] a0,
                        input logic v1, input logic [8:0] a1,
                        input logic e0, input logic e1);
        logic [8:0] ea;
        exp_t       e;
        int         lat;
        @(posedge clk);
        #1;
        reset_n        = rn;
        if2.req0_valid = (sel == 0) ? v0 : 1'b0;
        if2.req0_addr  = (sel == 0) ? a0 : 9'd0;
        if2.req1_valid = (sel == 0) ? v1 : 1'b0;
        if2.req1_addr  = (sel == 0) ? a1 : 9'd0;
        if1.req0_valid = (sel == 1) ? v0 : 1'b0;
        if1.req0_addr  = (sel == 1) ? a0 : 9'd0;
        if1.req1_valid = (sel == 1) ? v1 : 1'b0;
        if1.req1_addr  = (sel == 1) ? a1 : 9'd0;
        @(negedge clk);
        ea  = e0 ? a0 : (e1 ? a1 : 9'd0);
        lat = (sel == 0) ? 2 : 1;
        if (sel == 0) begin
            chk("req0_ready", {31'd0, if2.req0_ready}, {31'd0, e0});
            chk("req1_ready", {31'd0, if2.req1_ready}, {31'd0, e1});
            chk("bram_en", {31'd0, if2.bram_en}, {31'd0, e0 | e1});
            chk("bram_addr", {23'd0, if2.bram_addr}, {23'd0, ea});
        end else begin
            chk("l1_req0_ready", {31'd0, if1.req0_ready}, {31'd0, e0});
            chk("l1_req1_ready", {31'd0, if1.req1_ready}, {31'd0, e1});
            chk("l1_bram_en", {31'd0, if1.bram_en}, {31'd0, e0 | e1});
            chk("l1_bram_addr", {23'd0, if1.bram_addr}, {23'd0, ea});
        end
        if (e0 || e1) begin
            e.port = e1 ? 1 : 0;
            e.data = mem_word(ea);
            e.due  = cyc + lat + 1;
            $display("issue dut%0d cycle %0d port %0d addr %0h expect %0h at cycle %0d",
                     sel, cyc, e.port, ea, e.data, e.due);
            if (sel == 0) q_l2.push_back(e);
            else          q_l1.push_back(e);
        end
    endtask

    task automatic idle(input int sel, input int n);
        for (int i = 0; i < n; i++) step(sel, 1'b1, 1'b0, 9'd0, 1'b0, 9'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        if2.req0_valid = 1'b0; if2.req0_addr = 9'd0;
        if2.req1_valid = 1'b0; if2.req1_addr = 9'd0;
        if1.req0_valid = 1'b0; if1.req0_addr = 9'd0;
        if1.req1_valid = 1'b0; if1.req1_addr = 9'd0;

        // Reset held with both ports requesting: nothing is granted.
        for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b1, 9'd5, 1'b1, 9'd9, 1'b0, 1'b0);

        // Contention from the first cycle out of reset: 0,1,0,1,...
        for (int i = 0; i < 8; i++)
            step(0, 1'b1, 1'b1, 9'd5, 1'b1, 9'd9, (i % 2) == 0, (i % 2) == 1);
        idle(0, 4);

        // Single-port streaming.
        for (int a = 0; a < 4; a++) step(0, 1'b1, 1'b1, 9'(a), 1'b0, 9'd0, 1'b1, 1'b0);
        idle(0, 4);

        // Fairness history: port 1 served last, so port 0 wins the first tie.
        step(0, 1'b1, 1'b0, 9'd0,    1'b1, 9'h020, 1'b0, 1'b1);
        step(0, 1'b1, 1'b0, 9'd0,    1'b1, 9'h021, 1'b0, 1'b1);
        step(0, 1'b1, 1'b1, 9'h030,  1'b1, 9'h031, 1'b1, 1'b0);
        step(0, 1'b1, 1'b0, 9'd0,    1'b1, 9'h031, 1'b0, 1'b1);
        idle(0, 4);

        // Reset right after a port 0 accept: no response, and the next tie goes to port 0.
        step(0, 1'b1, 1'b1, 9'd7,    1'b0, 9'd0,   1'b1, 1'b0);
        step(0, 1'b0, 1'b0, 9'd0,    1'b0, 9'd0,   1'b0, 1'b0);
        step(0, 1'b1, 1'b1, 9'h00A,  1'b1, 9'h00B, 1'b1, 1'b0);
        step(0, 1'b1, 1'b0, 9'd0,    1'b1, 9'h00B, 1'b0, 1'b1);
        idle(0, 5);

        // LATENCY=1 instance: response two cycles after accept, data held.
        step(1, 1'b1, 1'b0, 9'd0, 1'b1, 9'h1FF, 1'b0, 1'b1);
        idle(1, 3);
        step(1, 1'b1, 1'b0, 9'd0, 1'b1, 9'h010, 1'b0, 1'b1);
        idle(1, 4);

        chk("drain_dut0", q_l2.size(), 32'd0);
        chk("drain_dut1", q_l1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
